pipelined_addsub: RTL and testbench
===================================

# pipelined_addsub

Parametrised, pipelined add/subtract unit: the next generation of the team's registered full adder. Operands are split into equal carry chunks, each resolved in its own pipeline stage, so wide adders close timing at high clock rates. A valid/ready handshake on both sides carries backpressure. The block also adds a subtract mode and a signed-overflow flag. It sits between operand-producing datapath logic and any consumer that can stall.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline stages = carry chunks; chunk width CW = WIDTH/STAGES; STAGES ≥ 1.
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for sub.
- sub  in  1  0: S = A + B + cin; 1: S = A − B − cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- s  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  add: carry-out. Sub: 1 = no borrow (A ≥ B + cin, unsigned).
- ovf  out  1  two's-complement signed overflow of the result.

## Operation
- Subtraction is computed as A + ~B + !cin. The cout and ovf flags are taken directly from that internal sum.
- Stage k (0..STAGES−1) adds chunk k of the operands plus the carry from stage k−1. Stage 0 uses the effective carry-in.
- Result chunks already computed are carried forward through the later stages. Operand chunks not yet consumed are delayed (skewed) alongside them.
- The final stage also computes ovf: (sign A == sign B') && (sign S != sign A), where B' is the effective second operand (~B when sub = 1).
- Each stage holds a valid bit. A stage with valid = 0 holds don't-care data, but its data must not change a visible output.
- Advance enable: en = !out_valid || out_ready. All stages shift together when en = 1 and hold when en = 0.
- in_ready = en, combinational from out_valid and out_ready only. It does not depend on in_valid.
- A beat is accepted on a rising edge when in_valid && in_ready. A bubble (valid = 0) enters stage 0 when in_valid = 0 and en = 1.
- Results leave in acceptance order. No beat is dropped or duplicated.
- s, cout and ovf are registered outputs and are stable while out_valid && !out_ready.
- STAGES = 1 degenerates to a single registered adder with the handshake. Behaviour is otherwise identical.

## Timing
- Reset (asynchronous): all stage valid bits = 0, out_valid = 0, s = 0, cout = 0, ovf = 0. After reset, in_ready = 1.
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+STAGES−1, provided no stall occurs.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: while out_valid = 1 and out_ready = 0, in_ready = 0 and the whole pipeline freezes. Bubbles are not compressed.
- Simultaneous out_ready and in_valid when the pipeline is full: the output beat retires and the input is accepted on the same edge.
- Reset asserted mid-stream: all in-flight beats are discarded with no partial output. After deassertion the next accepted beat is the first result.
- Wrap-around: results are modulo 2^WIDTH. Overflow is signalled only via cout and ovf, never by saturation.

## Test plan
- WIDTH=8, STAGES=2, add. Drive a=0xFF, b=0x01, cin=0 -> one cycle later s=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> s=0x80, cout=0, ovf=1.
- WIDTH=8, STAGES=2, sub. Drive a=0x05, b=0x07, cin=0 -> s=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01 -> s=0x7F, cout=1, ovf=1.
- WIDTH=32, STAGES=4. Stream 100 random beats with out_ready=1 -> results match a golden model in order, out_valid first asserts 3 cycles after the first accepted beat, and throughput is 1 beat/cycle.
- WIDTH=32, STAGES=4, random out_ready (50%). Check in_ready == (!out_valid || out_ready) every cycle; s/cout/ovf stay stable while stalled; the sequence has no loss or duplication.
- Carry across every chunk boundary: a=0xFFFFFFFF, b=0, cin=1 -> s=0, cout=1. Then sub with a=0, b=0, cin=1 -> s=0xFFFFFFFF, cout=0.
- Assert reset with 3 beats in flight -> out_valid=0 and s=0 immediately (asynchronous). After release, the first result is the first beat sent after reset.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - operand/result handshake bundle for pipelined_addsub
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  // Upstream side: one operand beat per accepted handshake.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;

  // Downstream side: registered result beat with its flags.
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  // Environment driving operands and consuming results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  // The add/subtract unit itself.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - chunked-carry pipelined add/subtract unit with valid/ready
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               reset,
  pipelined_addsub_if.slave  bus
);
  // WIDTH must be a multiple of STAGES; each stage resolves one CW-bit chunk.
  localparam int CW = WIDTH / STAGES;

  // Single advance enable: the whole pipe moves or the whole pipe holds.
  logic en;

  // Per-stage state. Stage k holds result chunks 0..k, the carry out of
  // chunk k, and the full operands so later stages can consume their chunks.
  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0]             carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0]  b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0]  res_q, res_d;
  logic                          ovf_q, ovf_d;

  // What each stage sees on its input side: the bus for stage 0, the
  // previous stage's registers otherwise.
  logic [STAGES-1:0]             src_valid;
  logic [STAGES-1:0]             src_carry;
  logic [STAGES-1:0][WIDTH-1:0]  src_a;
  logic [STAGES-1:0][WIDTH-1:0]  src_b;
  logic [STAGES-1:0][WIDTH-1:0]  src_res;

  // One chunk's sum including its carry out.
  logic [CW:0] chunk_sum;

  assign en            = !valid_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.s         = res_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  assign bus.ovf       = ovf_q;

  // Route stage inputs; subtraction is folded in at entry as A + ~B + !cin.
  always_comb begin
    src_valid[0] = bus.in_valid;
    src_a[0]     = bus.a;
    src_b[0]     = bus.sub ? ~bus.b : bus.b;
    src_carry[0] = bus.cin ^ bus.sub;
    src_res[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_res[k]   = res_q[k-1];
    end
  end

  // Compute each stage's next contents; stages only load on a valid beat so
  // bubbles never disturb the held result on the outputs.
  always_comb begin
    valid_d   = valid_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    chunk_sum = '0;
    if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          chunk_sum = {1'b0, src_a[k][k*CW +: CW]}
                    + {1'b0, src_b[k][k*CW +: CW]}
                    + {{CW{1'b0}}, src_carry[k]};
          a_d[k]                 = src_a[k];
          b_d[k]                 = src_b[k];
          res_d[k]               = src_res[k];
          res_d[k][k*CW +: CW]   = chunk_sum[CW-1:0];
          carry_d[k]             = chunk_sum[CW];
          // The top chunk holds the sign bit, so overflow is known here.
          if (k == STAGES - 1) begin
            ovf_d = (src_a[k][WIDTH-1] == src_b[k][WIDTH-1])
                 && (chunk_sum[CW-1] != src_a[k][WIDTH-1]);
          end
        end
      end
    end
  end

  // Pipeline registers; reset discards every in-flight beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(8))  bus8 ();
  pipelined_addsub_if #(.WIDTH(32)) bus32 ();

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  // Reference arithmetic from integer math, independent of the chunked carry.
  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
    exp_t        e;
    longint      ua, ub, sa, sb, c, tr;
    logic [32:0] full;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = longint'({63'b0, cin});
    if (!sub) begin
      full   = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      e.s    = full[31:0];
      e.cout = full[32];
      tr     = sa + sb + c;
    end else begin
      e.s    = a - b - {31'b0, cin};
      e.cout = (ua >= ub + c);
      tr     = sa - sb - c;
    end
    e.ovf = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;  bus8.sub = 1'b0;
    bus8.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus32.out_ready = 1'b1;
    #1;
    tests_run++;
    if ({bus8.out_valid, bus8.s, bus8.cout, bus8.ovf, bus8.in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset8: got v=%0b s=%h c=%0b o=%0b rdy=%0b, want 0 00 0 0 1",
               bus8.out_valid, bus8.s, bus8.cout, bus8.ovf, bus8.in_ready);
    end
    tests_run++;
    if ({bus32.out_valid, bus32.s, bus32.cout, bus32.ovf, bus32.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset32: got v=%0b s=%h c=%0b o=%0b rdy=%0b, want 0 00000000 0 0 1",
               bus32.out_valid, bus32.s, bus32.cout, bus32.ovf, bus32.in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Two-beat directed sequence on the 8-bit, 2-stage instance.
  task automatic test_addsub8(input string name, input logic sub,
                              input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] s0,
                              input logic c0, input logic o0,
                              input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] s1,
                              input logic c1, input logic o1);
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.a = a0; bus8.b = b0; bus8.cin = 1'b0; bus8.sub = sub;
    @(negedge clk);
    tests_run++;
    if (bus8.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_early: out_valid=%0b, want 0", name, bus8.out_valid);
    end
    bus8.a = a1; bus8.b = b1;
    @(negedge clk);
    tests_run++;
    if ({bus8.out_valid, bus8.s, bus8.cout, bus8.ovf} !== {1'b1, s0, c0, o0}) begin
      tests_failed++;
      $display("FAIL %s_beat0: got v=%0b s=%h c=%0b o=%0b, want 1 %h %0b %0b",
               name, bus8.out_valid, bus8.s, bus8.cout, bus8.ovf, s0, c0, o0);
    end
    bus8.in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus8.out_valid, bus8.s, bus8.cout, bus8.ovf} !== {1'b1, s1, c1, o1}) begin
      tests_failed++;
      $display("FAIL %s_beat1: got v=%0b s=%h c=%0b o=%0b, want 1 %h %0b %0b",
               name, bus8.out_valid, bus8.s, bus8.cout, bus8.ovf, s1, c1, o1);
    end
    @(negedge clk);
    tests_run++;
    if ({bus8.out_valid, bus8.s} !== {1'b0, s1}) begin
      tests_failed++;
      $display("FAIL %s_drain: got v=%0b s=%h, want 0 %h (held)", name, bus8.out_valid, bus8.s, s1);
    end
  endtask

  task automatic test_stream();
    int   accepted  = 0;
    int   retired   = 0;
    int   first_acc = -1;
    int   first_val = -1;
    int   last_acc  = -1;
    int   gaps      = 0;
    int   cyc       = 0;
    exp_t e;
    exp_t got;
    bus32.out_ready = 1'b1;
    while (retired < 100 && cyc < 400) begin
      @(negedge clk);
      if (bus32.out_valid) begin
        if (first_val < 0) first_val = cyc;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL stream_extra: result s=%h with nothing outstanding", bus32.s);
        end else begin
          e = exp_q.pop_front();
          got.s = bus32.s; got.cout = bus32.cout; got.ovf = bus32.ovf;
          if (got !== e) begin
            tests_failed++;
            $display("FAIL stream_beat%0d: got s=%h c=%0b o=%0b, want s=%h c=%0b o=%0b",
                     retired, got.s, got.cout, got.ovf, e.s, e.cout, e.ovf);
          end
        end
        retired++;
      end else if (first_val >= 0) begin
        gaps++;
      end
      if (accepted < 100) begin
        bus32.in_valid = 1'b1;
        bus32.a = $urandom; bus32.b = $urandom;
        bus32.cin = 1'($urandom_range(0, 1)); bus32.sub = 1'($urandom_range(0, 1));
      end else begin
        bus32.in_valid = 1'b0;
      end
      #1;
      if (bus32.in_valid && bus32.in_ready) begin
        exp_q.push_back(model32(bus32.a, bus32.b, bus32.cin, bus32.sub));
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        accepted++;
      end
      cyc++;
    end
    bus32.in_valid = 1'b0;
    tests_run++;
    if (retired != 100) begin
      tests_failed++;
      $display("FAIL stream_count: retired %0d, want 100", retired);
    end
    // Accepted on the edge after negedge i, first visible at negedge i+STAGES.
    tests_run++;
    if (first_val - first_acc != 4) begin
      tests_failed++;
      $display("FAIL stream_latency: %0d cycles, want 4", first_val - first_acc);
    end
    tests_run++;
    if (gaps != 0 || last_acc - first_acc != 99) begin
      tests_failed++;
      $display("FAIL stream_throughput: gaps=%0d accept_span=%0d, want 0 and 99", gaps, last_acc - first_acc);
    end
  endtask

  task automatic test_backpressure();
    int          sent    = 0;
    int          retired = 0;
    int          cyc     = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_s  = '0;
    logic        prev_c  = 1'b0;
    logic        prev_o  = 1'b0;
    exp_t        e;
    exp_t        got;
    exp_q.delete();
    while (retired < 100 && cyc < 2000) begin
      @(negedge clk);
      if (prev_stall) begin
        tests_run++;
        if ({bus32.out_valid, bus32.s, bus32.cout, bus32.ovf} !== {1'b1, prev_s, prev_c, prev_o}) begin
          tests_failed++;
          $display("FAIL bp_stable: got v=%0b s=%h c=%0b o=%0b, want 1 %h %0b %0b",
                   bus32.out_valid, bus32.s, bus32.cout, bus32.ovf, prev_s, prev_c, prev_o);
        end
      end
      bus32.out_ready = 1'($urandom_range(0, 1));
      if (bus32.out_valid && bus32.out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL bp_extra: result s=%h with nothing outstanding", bus32.s);
        end else begin
          e = exp_q.pop_front();
          got.s = bus32.s; got.cout = bus32.cout; got.ovf = bus32.ovf;
          if (got !== e) begin
            tests_failed++;
            $display("FAIL bp_beat%0d: got s=%h c=%0b o=%0b, want s=%h c=%0b o=%0b",
                     retired, got.s, got.cout, got.ovf, e.s, e.cout, e.ovf);
          end
        end
        retired++;
      end
      prev_stall = bus32.out_valid && !bus32.out_ready;
      prev_s = bus32.s; prev_c = bus32.cout; prev_o = bus32.ovf;
      if (sent < 100) begin
        bus32.in_valid = ($urandom_range(0, 3) != 0);
        bus32.a = $urandom; bus32.b = $urandom;
        bus32.cin = 1'($urandom_range(0, 1)); bus32.sub = 1'($urandom_range(0, 1));
      end else begin
        bus32.in_valid = 1'b0;
      end
      #1;
      tests_run++;
      if (bus32.in_ready !== (!bus32.out_valid || bus32.out_ready)) begin
        tests_failed++;
        $display("FAIL bp_in_ready: got %0b, want %0b (out_valid=%0b out_ready=%0b)",
                 bus32.in_ready, !bus32.out_valid || bus32.out_ready, bus32.out_valid, bus32.out_ready);
      end
      if (bus32.in_valid && bus32.in_ready) begin
        exp_q.push_back(model32(bus32.a, bus32.b, bus32.cin, bus32.sub));
        sent++;
      end
      cyc++;
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    tests_run++;
    if (retired != 100 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_count: retired %0d outstanding %0d, want 100 and 0", retired, exp_q.size());
    end
  endtask

  task automatic test_carry_chain();
    int n;
    bus32.out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bus32.in_valid = 1'b1;
      bus32.a   = (t == 0) ? 32'hFFFF_FFFF : 32'h0;
      bus32.b   = 32'h0;
      bus32.cin = 1'b1;
      bus32.sub = (t == 1);
      @(negedge clk);
      bus32.in_valid = 1'b0;
      n = 0;
      while (!bus32.out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      tests_run++;
      if (t == 0 && {bus32.out_valid, bus32.s, bus32.cout, bus32.ovf} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL carry_add: got v=%0b s=%h c=%0b o=%0b, want 1 00000000 1 0",
                 bus32.out_valid, bus32.s, bus32.cout, bus32.ovf);
      end
      if (t == 1 && {bus32.out_valid, bus32.s, bus32.cout, bus32.ovf} !== {1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL carry_sub: got v=%0b s=%h c=%0b o=%0b, want 1 ffffffff 0 0",
                 bus32.out_valid, bus32.s, bus32.cout, bus32.ovf);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int results = 0;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus32.in_valid = 1'b1;
      bus32.a = 32'hA000_0000 + i; bus32.b = 32'h1; bus32.cin = 1'b0; bus32.sub = 1'b0;
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus32.out_valid, bus32.s, bus32.cout, bus32.ovf, bus32.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL midreset_async: got v=%0b s=%h c=%0b o=%0b rdy=%0b, want 0 00000000 0 0 1",
               bus32.out_valid, bus32.s, bus32.cout, bus32.ovf, bus32.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.a = 32'h1234_5678; bus32.b = 32'h1111_1111; bus32.cin = 1'b0; bus32.sub = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus32.in_valid = 1'b0;
      if (bus32.out_valid) begin
        if (results == 0) begin
          tests_run++;
          if ({bus32.s, bus32.cout, bus32.ovf} !== {32'h2345_6789, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midreset_first: got s=%h c=%0b o=%0b, want 23456789 0 0",
                     bus32.s, bus32.cout, bus32.ovf);
          end
        end
        results++;
      end
    end
    tests_run++;
    if (results != 1) begin
      tests_failed++;
      $display("FAIL midreset_count: %0d results after reset, want 1", results);
    end
  endtask

  initial begin
    test_reset();
    test_addsub8("add8", 1'b0,
                 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0,
                 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    test_addsub8("sub8", 1'b1,
                 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0,
                 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    test_stream();
    test_backpressure();
    test_carry_chain();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
